// File: rtl/dispatch_steer.sv
// ---------------------------------------------------------------------------
// dispatch_steer
//   Dispatch stage between decode and the issue queues. Accepts one decoded
//   instruction per cycle, allocates a destination tag from an internal
//   circular free list (refilled by the CDB), and steers the instruction
//   through a one-entry holding register to one of NUM_QUEUES issue queues.
//   Intake stalls after a branch until the CDB resolves it.
//
// Handshakes (strict valid/ready on both sides):
//   A transfer happens in the cycle where valid and ready are both high at
//   the rising clock edge. A producer holding valid keeps its data stable
//   until the transfer; ready may depend combinationally on valid-side
//   inputs (in_has_rd) but valid never depends on ready.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   in_valid/in_ready decode-side handshake
//   in_qsel           one-hot target queue
//   in_has_rd         instruction needs a destination tag
//   in_is_branch      instruction is a conditional branch
//   in_payload        opaque decoded bundle
//   out_valid         one-hot valid towards the issue queues
//   out_ready         per-queue ready
//   out_payload       held payload
//   out_tag           allocated tag, meaningful when out_tag_valid
//   cdb_valid/tag     completed tag returned to the free list
//   cdb_branch        CDB broadcast resolves the outstanding branch
//   free_count        number of free tags
//   branch_stall      FSM state debug view (1 = waiting on branch)
//   err_qsel          sticky: an accepted in_qsel was not one-hot
// ---------------------------------------------------------------------------
module dispatch_steer #(
  parameter int NUM_QUEUES = 4,
  parameter int TAG_W      = 6,
  parameter int NUM_TAGS   = 64,
  parameter int DATA_W     = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_QUEUES-1:0] in_qsel,
  input  logic                  in_has_rd,
  input  logic                  in_is_branch,
  input  logic [DATA_W-1:0]     in_payload,
  output logic [NUM_QUEUES-1:0] out_valid,
  input  logic [NUM_QUEUES-1:0] out_ready,
  output logic [DATA_W-1:0]     out_payload,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_tag_valid,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic                  cdb_branch,
  output logic [TAG_W:0]        free_count,
  output logic                  branch_stall,
  output logic                  err_qsel
);

  localparam int PTR_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_TAGS - 1);
  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W + 1)'(NUM_TAGS);

  localparam logic [0:0] S_DISPATCH    = 1'b0;
  localparam logic [0:0] S_BRANCHSTALL = 1'b1;

  // FSM
  logic [0:0] state_q, state_d;

  // Holding register
  logic                  hold_valid_q, hold_valid_d;
  logic [NUM_QUEUES-1:0] hold_qsel_q, hold_qsel_d;
  logic [DATA_W-1:0]     hold_payload_q, hold_payload_d;
  logic [TAG_W-1:0]      hold_tag_q, hold_tag_d;
  logic                  hold_tag_valid_q, hold_tag_valid_d;

  // Free list
  logic [TAG_W-1:0] fl_q [NUM_TAGS];
  logic [TAG_W-1:0] fl_d [NUM_TAGS];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_W:0]   free_count_q, free_count_d;

  logic err_qsel_q, err_qsel_d;

  logic fire, accept, pop, push, qsel_zero, qsel_onehot;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    qsel_zero   = (in_qsel == '0);
    qsel_onehot = !qsel_zero && ((in_qsel & (in_qsel - NUM_QUEUES'(1))) == '0);

    fire = hold_valid_q & (|(hold_qsel_q & out_ready));

    // Registered free_count only: a same-cycle CDB return cannot unblock
    // a has_rd instruction, which keeps in_ready off the CDB timing path.
    in_ready = (state_q == S_DISPATCH) & (~hold_valid_q | fire) &
               (~in_has_rd | (free_count_q != '0));
    accept = in_valid & in_ready;

    // An all-zero qsel is swallowed without consuming a tag.
    pop  = accept & in_has_rd & ~qsel_zero;
    push = cdb_valid & (free_count_q != FULL_CNT);
  end

  // Holding register and error flag
  always_comb begin
    hold_valid_d     = hold_valid_q;
    hold_qsel_d      = hold_qsel_q;
    hold_payload_d   = hold_payload_q;
    hold_tag_d       = hold_tag_q;
    hold_tag_valid_d = hold_tag_valid_q;
    err_qsel_d       = err_qsel_q;

    if (fire) hold_valid_d = 1'b0;

    if (accept) begin
      if (!qsel_onehot) err_qsel_d = 1'b1;
      if (!qsel_zero) begin
        hold_valid_d     = 1'b1;
        hold_qsel_d      = in_qsel;
        hold_payload_d   = in_payload;
        hold_tag_d       = fl_q[rd_ptr_q];
        hold_tag_valid_d = in_has_rd;
      end
    end
  end

  // Free list
  always_comb begin
    fl_d         = fl_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    free_count_d = free_count_q;

    if (push) begin
      fl_d[wr_ptr_q] = cdb_tag;
      wr_ptr_d       = next_ptr(wr_ptr_q);
    end
    if (pop) rd_ptr_d = next_ptr(rd_ptr_q);

    case ({push, pop})
      2'b10:   free_count_d = free_count_q + (TAG_W + 1)'(1);
      2'b01:   free_count_d = free_count_q - (TAG_W + 1)'(1);
      default: free_count_d = free_count_q;
    endcase
  end

  // FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DISPATCH:    if (accept && in_is_branch) state_d = S_BRANCHSTALL;
      S_BRANCHSTALL: if (cdb_valid && cdb_branch) state_d = S_DISPATCH;
      default:       state_d = S_DISPATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= S_DISPATCH;
      hold_valid_q     <= 1'b0;
      hold_qsel_q      <= '0;
      hold_payload_q   <= '0;
      hold_tag_q       <= '0;
      hold_tag_valid_q <= 1'b0;
      err_qsel_q       <= 1'b0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      free_count_q     <= FULL_CNT;
      for (int i = 0; i < NUM_TAGS; i++) fl_q[i] <= TAG_W'(i);
    end else begin
      state_q          <= state_d;
      hold_valid_q     <= hold_valid_d;
      hold_qsel_q      <= hold_qsel_d;
      hold_payload_q   <= hold_payload_d;
      hold_tag_q       <= hold_tag_d;
      hold_tag_valid_q <= hold_tag_valid_d;
      err_qsel_q       <= err_qsel_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      free_count_q     <= free_count_d;
      fl_q             <= fl_d;
    end
  end

  assign out_valid     = hold_valid_q ? hold_qsel_q : '0;
  assign out_payload   = hold_payload_q;
  assign out_tag       = hold_tag_q;
  assign out_tag_valid = hold_tag_valid_q;
  assign free_count    = free_count_q;
  assign branch_stall  = (state_q == S_BRANCHSTALL);
  assign err_qsel      = err_qsel_q;

endmodule
